// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified memory between instruction fetch and data access.
// Serializes requests, holds the memory for MEM_LATENCY cycles, then pulses the owner's ready.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             if_req_i,
    input  logic [31:0]      if_addr_i,
    output logic [31:0]      if_rdata_o,
    output logic             if_ready_o,
    input  logic             dm_read_i,
    input  logic             dm_write_i,
    input  logic [31:0]      dm_addr_i,
    input  logic [31:0]      dm_wdata_i,
    output logic [31:0]      dm_rdata_o,
    output logic             dm_ready_o,
    output logic             mem_en_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic [31:0]      mem_rdata_i,
    output logic             stall_if_o,
    output logic             stall_mem_o,
    output logic [CNT_W-1:0] conflict_cnt_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
    typedef enum logic {FETCH, DATA} owner_e;

    localparam logic [3:0]       CNT_INIT = 4'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q;
    owner_e           owner_q;
    logic [3:0]       cnt_q;
    logic             mem_en_q;
    logic             mem_we_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      mem_wdata_q;
    logic [31:0]      if_rdata_q;
    logic [31:0]      dm_rdata_q;
    logic             if_ready_q;
    logic             dm_ready_q;
    logic [CNT_W-1:0] conflict_cnt_q;

    logic             dm_req;
    logic [CNT_W-1:0] conflict_cnt_d;

    assign dm_req         = dm_read_i | dm_write_i;
    assign conflict_cnt_d = (if_req_i && dm_req && conflict_cnt_q != CNT_MAX)
                            ? conflict_cnt_q + CNT_ONE : conflict_cnt_q;

    // Data wins arbitration: the older instruction in MEM must finish before a newer fetch.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            owner_q        <= FETCH;
            cnt_q          <= 4'd0;
            mem_en_q       <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= 32'd0;
            mem_wdata_q    <= 32'd0;
            if_rdata_q     <= 32'd0;
            dm_rdata_q     <= 32'd0;
            if_ready_q     <= 1'b0;
            dm_ready_q     <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    conflict_cnt_q <= conflict_cnt_d;
                    if (dm_req) begin
                        state_q     <= ACCESS;
                        owner_q     <= DATA;
                        cnt_q       <= CNT_INIT;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= dm_write_i;
                        mem_addr_q  <= dm_addr_i;
                        mem_wdata_q <= dm_wdata_i;
                    end else if (if_req_i) begin
                        state_q    <= ACCESS;
                        owner_q    <= FETCH;
                        cnt_q      <= CNT_INIT;
                        mem_en_q   <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= if_addr_i;
                    end
                end
                ACCESS: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        // Stores leave dm_rdata untouched so the last load value survives.
                        if (!mem_we_q) begin
                            if (owner_q == DATA) dm_rdata_q <= mem_rdata_i;
                            else                 if_rdata_q <= mem_rdata_i;
                        end
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        if (owner_q == DATA) dm_ready_q <= 1'b1;
                        else                 if_ready_q <= 1'b1;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if_ready_q <= 1'b0;
                    dm_ready_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_rdata_o     = if_rdata_q;
    assign if_ready_o     = if_ready_q;
    assign dm_rdata_o     = dm_rdata_q;
    assign dm_ready_o     = dm_ready_q;
    assign mem_en_o       = mem_en_q;
    assign mem_we_o       = mem_we_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign conflict_cnt_o = conflict_cnt_q;
    assign stall_if_o     = if_req_i & ~if_ready_q;
    assign stall_mem_o    = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a latency-2 instance with a 4-bit conflict counter
// and a latency-1 instance, each backed by an address-hashed memory model and a scoreboard.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;

    logic        ifReq, dmRead, dmWrite;
    logic [31:0] ifAddr, dmAddr, dmWdata;
    logic [31:0] ifRdata, dmRdata, memAddr, memWdata, memRdata;
    logic        ifReady, dmReady, memEn, memWe, stallIf, stallMem;
    logic [3:0]  conflictCnt;

    logic        ifReq1, dmRead1, dmWrite1;
    logic [31:0] ifAddr1, dmAddr1, dmWdata1;
    logic [31:0] ifRdata1, dmRdata1, memAddr1, memWdata1, memRdata1;
    logic        ifReady1, dmReady1, memEn1, memWe1, stallIf1, stallMem1;
    logic [15:0] conflictCnt1;

    int checks = 0;
    int fails  = 0;
    logic [31:0] expFetchQ[$];
    logic [31:0] expDataQ[$];
    logic [31:0] expFetch1Q[$];
    logic [31:0] lastLoad;

    function automatic logic [31:0] memModel(input logic [31:0] a);
        if (a == 32'd0) return 32'h8C010004;
        return {a[15:0], ~a[15:0]};
    endfunction

    assign memRdata  = memModel(memAddr);
    assign memRdata1 = memModel(memAddr1);

    mem_port_arbiter #(.MEM_LATENCY(2), .CNT_W(4)) dut (
        .clk_i(clk), .reset_i(reset),
        .if_req_i(ifReq), .if_addr_i(ifAddr), .if_rdata_o(ifRdata), .if_ready_o(ifReady),
        .dm_read_i(dmRead), .dm_write_i(dmWrite), .dm_addr_i(dmAddr), .dm_wdata_i(dmWdata),
        .dm_rdata_o(dmRdata), .dm_ready_o(dmReady),
        .mem_en_o(memEn), .mem_we_o(memWe), .mem_addr_o(memAddr), .mem_wdata_o(memWdata),
        .mem_rdata_i(memRdata), .stall_if_o(stallIf), .stall_mem_o(stallMem),
        .conflict_cnt_o(conflictCnt)
    );

    mem_port_arbiter #(.MEM_LATENCY(1), .CNT_W(16)) dut1 (
        .clk_i(clk), .reset_i(reset),
        .if_req_i(ifReq1), .if_addr_i(ifAddr1), .if_rdata_o(ifRdata1), .if_ready_o(ifReady1),
        .dm_read_i(dmRead1), .dm_write_i(dmWrite1), .dm_addr_i(dmAddr1), .dm_wdata_i(dmWdata1),
        .dm_rdata_o(dmRdata1), .dm_ready_o(dmReady1),
        .mem_en_o(memEn1), .mem_we_o(memWe1), .mem_addr_o(memAddr1), .mem_wdata_o(memWdata1),
        .mem_rdata_i(memRdata1), .stall_if_o(stallIf1), .stall_mem_o(stallMem1),
        .conflict_cnt_o(conflictCnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [31:0] iaddr, input logic rd,
                                 input logic wr, input logic [31:0] daddr,
                                 input logic [31:0] wdata);
        ifReq   = req;
        ifAddr  = iaddr;
        dmRead  = rd;
        dmWrite = wr;
        dmAddr  = daddr;
        dmWdata = wdata;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: each ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ifReady) begin
            checkOutput("if_ready_expected", 32'(expFetchQ.size() != 0), 32'd1);
            if (expFetchQ.size() != 0) checkOutput("if_rdata", ifRdata, expFetchQ.pop_front());
        end
        if (dmReady) begin
            checkOutput("dm_ready_expected", 32'(expDataQ.size() != 0), 32'd1);
            if (expDataQ.size() != 0) checkOutput("dm_rdata", dmRdata, expDataQ.pop_front());
        end
        if (ifReady1) begin
            checkOutput("l1_if_ready_expected", 32'(expFetch1Q.size() != 0), 32'd1);
            if (expFetch1Q.size() != 0) checkOutput("l1_if_rdata", ifRdata1, expFetch1Q.pop_front());
        end
        if (dmReady1) checkOutput("l1_dm_ready_spurious", 32'(dmReady1), 32'd0);
    end

    initial begin
        reset = 1'b1;
        lastLoad = 32'd0;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        ifReq1 = 1'b0; ifAddr1 = 32'd0; dmRead1 = 1'b0; dmWrite1 = 1'b0;
        dmAddr1 = 32'd0; dmWdata1 = 32'd0;
        waitCycles(2);
        checkOutput("reset_mem_en", 32'(memEn), 32'd0);
        checkOutput("reset_mem_we", 32'(memWe), 32'd0);
        checkOutput("reset_mem_addr", memAddr, 32'd0);
        checkOutput("reset_mem_wdata", memWdata, 32'd0);
        checkOutput("reset_if_rdata", ifRdata, 32'd0);
        checkOutput("reset_dm_rdata", dmRdata, 32'd0);
        checkOutput("reset_readies", {30'd0, ifReady, dmReady}, 32'd0);
        checkOutput("reset_conflict", 32'(conflictCnt), 32'd0);
        reset = 1'b0;

        $display("[TB] single fetch");
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
        expFetchQ.push_back(32'h8C010004);
        waitCycles(1);
        checkOutput("fetch_grant_en", 32'(memEn), 32'd1);
        checkOutput("fetch_grant_we", 32'(memWe), 32'd0);
        checkOutput("fetch_grant_addr", memAddr, 32'h0);
        checkOutput("fetch_stall_if", 32'(stallIf), 32'd1);
        waitCycles(1);
        checkOutput("fetch_en_cycle2", 32'(memEn), 32'd1);
        checkOutput("fetch_not_ready_early", 32'(ifReady), 32'd0);
        waitCycles(1);
        checkOutput("fetch_en_dropped", 32'(memEn), 32'd0);
        checkOutput("fetch_ready", 32'(ifReady), 32'd1);
        checkOutput("fetch_rdata", ifRdata, 32'h8C010004);
        checkOutput("fetch_stall_released", 32'(stallIf), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
        waitCycles(1);
        checkOutput("fetch_ready_one_cycle", 32'(ifReady), 32'd0);
        checkOutput("fetch_stall_after", 32'(stallIf), 32'd0);

        $display("[TB] store");
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
        expDataQ.push_back(lastLoad);
        waitCycles(1);
        checkOutput("store_en", 32'(memEn), 32'd1);
        checkOutput("store_we", 32'(memWe), 32'd1);
        checkOutput("store_addr", memAddr, 32'h40);
        checkOutput("store_wdata", memWdata, 32'hDEADBEEF);
        checkOutput("store_stall_mem", 32'(stallMem), 32'd1);
        waitCycles(1);
        checkOutput("store_we_cycle2", 32'(memWe), 32'd1);
        checkOutput("store_wdata_cycle2", memWdata, 32'hDEADBEEF);
        waitCycles(1);
        checkOutput("store_ready", 32'(dmReady), 32'd1);
        checkOutput("store_we_dropped", 32'(memWe), 32'd0);
        checkOutput("store_dm_rdata_held", dmRdata, lastLoad);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        waitCycles(1);
        checkOutput("store_ready_one_cycle", 32'(dmReady), 32'd0);

        $display("[TB] simultaneous fetch and load");
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'd0);
        expDataQ.push_back(memModel(32'h200));
        expFetchQ.push_back(memModel(32'h100));
        waitCycles(1);
        checkOutput("conf_data_first_addr", memAddr, 32'h200);
        checkOutput("conf_count", 32'(conflictCnt), 32'd1);
        waitCycles(2);
        checkOutput("conf_dm_ready", 32'(dmReady), 32'd1);
        checkOutput("conf_if_not_ready", 32'(ifReady), 32'd0);
        dmRead = 1'b0;
        lastLoad = memModel(32'h200);
        waitCycles(1);
        checkOutput("conf_resp_idle_en", 32'(memEn), 32'd0);
        waitCycles(1);
        checkOutput("conf_fetch_grant_en", 32'(memEn), 32'd1);
        checkOutput("conf_fetch_grant_addr", memAddr, 32'h100);
        checkOutput("conf_count_stays", 32'(conflictCnt), 32'd1);
        waitCycles(2);
        checkOutput("conf_if_ready", 32'(ifReady), 32'd1);
        ifReq = 1'b0;
        waitCycles(1);

        $display("[TB] reset during access");
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h300, 32'd0);
        waitCycles(2);
        checkOutput("rst_in_access_en", 32'(memEn), 32'd1);
        reset = 1'b1;
        waitCycles(1);
        checkOutput("rst_mem_en", 32'(memEn), 32'd0);
        checkOutput("rst_dm_ready", 32'(dmReady), 32'd0);
        checkOutput("rst_dm_rdata", dmRdata, 32'd0);
        checkOutput("rst_conflict", 32'(conflictCnt), 32'd0);
        reset = 1'b0;
        lastLoad = 32'd0;
        expDataQ.push_back(memModel(32'h300));
        waitCycles(1);
        checkOutput("rst_regrant_en", 32'(memEn), 32'd1);
        checkOutput("rst_regrant_addr", memAddr, 32'h300);
        waitCycles(2);
        checkOutput("rst_regrant_ready", 32'(dmReady), 32'd1);
        dmRead = 1'b0;
        lastLoad = memModel(32'h300);
        waitCycles(1);

        $display("[TB] conflict counter saturation");
        applyStimulus(1'b1, 32'h500, 1'b0, 1'b1, 32'h40, 32'h12345678);
        for (int i = 0; i < 16; i++) begin
            expDataQ.push_back(lastLoad);
            waitCycles(1);
            checkOutput("sat_conflict_cnt", 32'(conflictCnt), (i < 15) ? 32'(i + 1) : 32'd15);
            waitCycles(3);
        end
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        waitCycles(2);
        checkOutput("sat_final", 32'(conflictCnt), 32'd15);

        $display("[TB] latency 1 back-to-back fetches");
        ifAddr1 = 32'h1000;
        ifReq1  = 1'b1;
        expFetch1Q.push_back(memModel(32'h1000));
        for (int k = 0; k < 4; k++) begin
            waitCycles(1);
            checkOutput("l1_grant_en", 32'(memEn1), 32'd1);
            checkOutput("l1_grant_addr", memAddr1, 32'h1000 + 32'(4 * k));
            waitCycles(1);
            checkOutput("l1_ready", 32'(ifReady1), 32'd1);
            checkOutput("l1_rdata_direct", ifRdata1, memModel(32'h1000 + 32'(4 * k)));
            if (k < 3) begin
                ifAddr1 = ifAddr1 + 32'd4;
                expFetch1Q.push_back(memModel(ifAddr1));
            end else begin
                ifReq1 = 1'b0;
            end
            waitCycles(1);
            checkOutput("l1_resp_ready_low", 32'(ifReady1), 32'd0);
        end

        waitCycles(3);
        checkOutput("fetch_queue_drained", 32'(expFetchQ.size()), 32'd0);
        checkOutput("data_queue_drained", 32'(expDataQ.size()), 32'd0);
        checkOutput("l1_queue_drained", 32'(expFetch1Q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
